// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter / delay-tick source.
//
// A value is programmed through a load handshake, then start/pause/stop control
// the count toward zero. tc is high for the single RUN cycle in which Q is zero.
// With auto_reload set at that point (and a non-zero reload value) the counter
// reloads and keeps running, giving a periodic tick of (N + 1) cycles.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   load_valid  in   load request
//   load_val    in   [WIDTH] value to load, qualified by load_valid
//   load_ready  out  load accepted this cycle (IDLE or ARMED)
//   auto_reload in   reload and continue at terminal count
//   start       in   begin or resume counting
//   pause       in   freeze counting
//   stop        in   abort, return to idle with Q = 0
//   Q           out  [WIDTH] current count
//   busy        out  state is RUN or HOLD
//   tc          out  terminal count: RUN and Q == 0
//   done        out  sticky, set on non-reloading completion; cleared by load
module countdown_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_val,
  output logic             load_ready,
  input  logic             auto_reload,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StRun   = 2'd2,
    StHold  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  logic             load_acc;
  logic             count_zero;

  always_comb begin
    load_ready = (state_q == StIdle) || (state_q == StArmed);
    busy       = (state_q == StRun) || (state_q == StHold);
    count_zero = (count_q == '0);
    tc         = (state_q == StRun) && count_zero;
    load_acc   = load_valid && load_ready;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = done_q;

    unique case (state_q)
      StIdle: begin
        // stop wins over a simultaneous load here as it does in ARMED.
        if (stop) begin
          count_d = '0;
        end else if (load_acc) begin
          reload_d = load_val;
          count_d  = load_val;
          done_d   = 1'b0;
          state_d  = StArmed;
        end
      end

      StArmed: begin
        if (stop) begin
          count_d = '0;
          state_d = StIdle;
        end else begin
          if (load_acc) begin
            reload_d = load_val;
            count_d  = load_val;
            done_d   = 1'b0;
          end
          // Entering RUN does not decrement; the first decrement is next edge.
          if (start) begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        if (stop) begin
          count_d = '0;
          state_d = StIdle;
        end else if (pause) begin
          state_d = StHold;
        end else if (!count_zero) begin
          count_d = count_q - 1'b1;
        end else if (auto_reload && (reload_q != '0)) begin
          count_d = reload_q;
        end else begin
          // Terminal: count already zero, never wraps.
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      StHold: begin
        if (stop) begin
          count_d = '0;
          state_d = StIdle;
        end else if (start) begin
          state_d = StRun;
        end
      end

      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign Q    = count_q;
  assign done = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         auto_reload = 1'b0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         stop = 1'b0;
  logic         load_ready;
  logic [W-1:0] q;
  logic         busy;
  logic         tc;
  logic         done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string        tag;
    logic [W+3:0] v;   // {Q, tc, busy, done, load_ready}
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_val   (load_val),
    .load_ready (load_ready),
    .auto_reload(auto_reload),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .Q          (q),
    .busy       (busy),
    .tc         (tc),
    .done       (done)
  );

  task automatic expect_out(input string tag, input logic [W-1:0] qv, input logic t,
                            input logic b, input logic d, input logic lr);
    exp_t e;
    e.tag = tag;
    e.v   = {qv, t, b, d, lr};
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t         e;
    logic [W+3:0] obs;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed no expectation, required one");
    end else begin
      e   = sb.pop_front();
      obs = {q, tc, busy, done, load_ready};
      assert (obs === e.v) else begin
        fails++;
        $error("FAIL %s: observed Q=%0d tc=%b busy=%b done=%b load_ready=%b, expected Q=%0d tc=%b busy=%b done=%b load_ready=%b",
               e.tag, obs[W+3:4], obs[3], obs[2], obs[1], obs[0],
               e.v[W+3:4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  endtask

  // Push the expectation for the state after the next edge, then compare.
  task automatic step(input string tag, input logic [W-1:0] qv, input logic t,
                      input logic b, input logic d, input logic lr);
    expect_out(tag, qv, t, b, d, lr);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    // 1. Reset then idle
    #2 rst_n = 1'b0;
    #2;
    expect_out("rst_asserted", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_out();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 2. One-shot load 5
    load_valid = 1'b1; load_val = 4'd5;
    step("t2_load", 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    load_valid = 1'b0; start = 1'b1;
    step("t2_start", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t2_q4", 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t2_q3", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t2_q2", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t2_q1", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t2_q0_tc", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("t2_done", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("t2_done_hold", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // 3. Auto-reload load 3; load attempt mid-run must be refused
    load_valid = 1'b1; load_val = 4'd3; auto_reload = 1'b1;
    step("t3_load", 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    load_valid = 1'b0; start = 1'b1;
    step("t3_start", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t3_a2", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t3_a1", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t3_a0_tc", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("t3_reload", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    load_valid = 1'b1; load_val = 4'd9;
    step("t3_b2_noload", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t3_b1_noload", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    load_valid = 1'b0;
    step("t3_b0_tc", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("t3_reload2", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    step("t3_stop", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    stop = 1'b0; auto_reload = 1'b0;

    // 4. Pause / resume, then pause+stop together
    load_valid = 1'b1; load_val = 4'd10;
    step("t4_load", 4'd10, 1'b0, 1'b0, 1'b0, 1'b1);
    load_valid = 1'b0; start = 1'b1;
    step("t4_start", 4'd10, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t4_q9", 4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t4_q8", 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t4_q7", 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    pause = 1'b1;
    step("t4_hold1", 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t4_hold2", 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    pause = 1'b0;
    step("t4_hold3", 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t4_hold4", 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    step("t4_resume", 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t4_q6", 4'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t4_q5", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    pause = 1'b1; stop = 1'b1;
    step("t4_pause_stop", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    pause = 1'b0; stop = 1'b0;

    // 5a. Load 0: one tc cycle, auto_reload has no effect with zero reload value
    auto_reload = 1'b1;
    load_valid = 1'b1; load_val = 4'd0;
    step("t5_load0", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    load_valid = 1'b0; start = 1'b1;
    step("t5_zero_tc", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t5_zero_done", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    auto_reload = 1'b0;

    // 5b. Max load counts down to 0 without wrapping
    load_valid = 1'b1; load_val = 4'd15;
    step("t5_load15", 4'd15, 1'b0, 1'b0, 1'b0, 1'b1);
    load_valid = 1'b0; start = 1'b1;
    step("t5_start15", 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int i = 14; i >= 1; i--) begin
      logic [W-1:0] v;
      v = W'(i);
      step("t5_max_count", v, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    step("t5_max_tc", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("t5_max_done", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // 5c. Load and start on the same ARMED edge take the new value
    load_valid = 1'b1; load_val = 4'd6;
    step("t5_arm6", 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    load_val = 4'd2; start = 1'b1;
    step("t5_load_start", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    load_valid = 1'b0; start = 1'b0;
    step("t5_ls_q1", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t5_ls_tc", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("t5_ls_done", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // 5d. stop in ARMED beats load and start
    load_valid = 1'b1; load_val = 4'd4;
    step("t5_arm4", 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    load_val = 4'd9; start = 1'b1; stop = 1'b1;
    step("t5_armed_stop", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    load_valid = 1'b0; start = 1'b0; stop = 1'b0;
    step("t5_idle_after", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 6. Asynchronous reset mid-RUN at Q = 4
    load_valid = 1'b1; load_val = 4'd6;
    step("t6_load", 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    load_valid = 1'b0; start = 1'b1;
    step("t6_start", 4'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t6_q5", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t6_q4", 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    expect_out("t6_async_rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_out();
    step("t6_rst_held", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #3 rst_n = 1'b1;
    step("t6_after_rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("t6_after_rst2", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_leftover: observed %0d pending, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
